mmu_map_ram: RTL

// - Responder end of the MMU mapping-RAM port: synchronous 256x8 map store answering mmu_int's MMU_ADDR/MMU_nRD/MMU_nWR/data strobes.
// - Replaces the external MMU SRAM on boards without one; sits beside mmu_int in the SBC09 core, clocked by the fast system clock.
// - Converts the asynchronous E-gated strobes into synchronous reads and writes.
// - After reset, self-initialises the map to the default (MMU-off) mapping.

---
 rtl/mmu_map_ram_pkg.sv | 28 ++
 rtl/mmu_map_ram_sync_ff.sv | 31 +++
 rtl/mmu_map_ram.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mmu_map_ram_pkg.sv
// mmu_pkg: shared widths, map type codes, FSM state type and the default
// (MMU-off) map-entry generator used by the mapping-RAM responder.
package mmu_pkg;

  localparam int MMU_IDX_W  = 8;
  localparam int MMU_SLOT_W = 3;

  // Map entry type codes (entry bits [7:6])
  localparam logic [1:0] MT_ROM0 = 2'b00;
  localparam logic [1:0] MT_ROM1 = 2'b01;
  localparam logic [1:0] MT_RAM  = 2'b10;
  localparam logic [1:0] MT_EXT  = 2'b11;

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_DRAIN = 2'b01,
    ST_RUN   = 2'b10
  } mmu_state_e;

  // MMU-off pattern: slot bit 2 (A15) selects ROM0 vs RAM, slot bit 0 is the
  // QA13 passthrough, and the low bits carry the A15:A14 page.
  function automatic logic [7:0] default_map(input logic [MMU_SLOT_W-1:0] s);
    logic [1:0] w_type;
    w_type = s[2] ? MT_ROM0 : MT_RAM;
    return {w_type, s[0], 3'b000, s[2:1]};
  endfunction

endpackage

// File: rtl/mmu_map_ram_sync_ff.sv
// mmu_sync_ff: N-stage synchroniser for an asynchronous level with
// single-cycle edge-detect pulses taken from the synchronised output.
// Ports:
//   i_clk   - sampling clock
//   i_d     - asynchronous input level
//   o_fall  - one-clk pulse when the synchronised level goes 1 -> 0
//   o_rise  - one-clk pulse when the synchronised level goes 0 -> 1
// The chain carries no reset: the consumer drops any captured state during
// its own reset, and the chain re-settles to the live input level meanwhile.
module mmu_sync_ff #(
  parameter int N = 2
) (
  input  logic i_clk,
  input  logic i_d,
  output logic o_fall,
  output logic o_rise
);

  logic [N-1:0] r_sync;
  logic         r_last;

  // Shift chain plus one history flop for edge detection
  always_ff @(posedge i_clk) begin
    r_sync <= {r_sync[N-2:0], i_d};
    r_last <= r_sync[N-1];
  end

  assign o_fall = r_last & ~r_sync[N-1];
  assign o_rise = ~r_last & r_sync[N-1];

endmodule

// File: rtl/mmu_map_ram.sv
// mmu_map_ram: synchronous 256x8 MMU map store answering mmu_int's strobes.
// Ports:
//   clk, rst           - system clock, synchronous active-high reset
//   MMU_ADDR           - {key[4:0], slot[2:0]}
//   MMU_nRD            - read enable, active low
//   MMU_nWR            - E-gated write strobe, active low (asynchronous)
//   MMU_DATA_in        - data driven by mmu_int
//   MMU_DATA_drv       - mmu_int is driving the bus
//   MMU_DATA_out       - resolved bus data back to mmu_int
//   init_done          - default fill complete
//   overrun            - sticky: a held write was replaced during the fill
module mmu_map_ram
  import mmu_pkg::*;
#(
  parameter bit INIT_ON_RESET = 1'b1,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MMU_IDX_W-1:0] MMU_ADDR,
  input  logic                 MMU_nRD,
  input  logic                 MMU_nWR,
  input  logic [7:0]           MMU_DATA_in,
  input  logic                 MMU_DATA_drv,
  output logic [7:0]           MMU_DATA_out,
  output logic                 init_done,
  output logic                 overrun
);

  logic [7:0]           r_mem [0:255];
  mmu_state_e           r_state;
  logic [MMU_IDX_W-1:0] r_idx;
  logic                 r_init_done;
  logic                 r_overrun;
  logic                 r_pend;
  logic [MMU_IDX_W-1:0] r_pend_addr;
  logic [7:0]           r_pend_data;
  logic                 r_cap_vld;
  logic [MMU_IDX_W-1:0] r_cap_addr;
  logic [7:0]           r_cap_data;
  logic [MMU_IDX_W-1:0] r_rd_addr;
  logic [7:0]           r_rd_data;

  logic                 w_fall;
  logic                 w_rise;
  logic                 w_commit;
  logic                 w_we;
  logic [MMU_IDX_W-1:0] w_waddr;
  logic [7:0]           w_wdata;

  mmu_sync_ff #(.N(SYNC_STAGES)) u_wr_sync (
    .i_clk  (clk),
    .i_d    (MMU_nWR),
    .o_fall (w_fall),
    .o_rise (w_rise)
  );

  // A rise only commits if its matching fall was captured since reset
  assign w_commit = w_rise & r_cap_vld;

  // Single RAM write port: fill, pending drain or live commit
  always_comb begin
    w_we    = 1'b0;
    w_waddr = 8'h00;
    w_wdata = 8'h00;
    if (rst) begin
      w_we = 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (INIT_ON_RESET) begin
            w_we    = 1'b1;
            w_waddr = r_idx;
            w_wdata = default_map(r_idx[2:0]);
          end else if (w_commit) begin
            w_we    = 1'b1;
            w_waddr = r_cap_addr;
            w_wdata = r_cap_data;
          end else begin
            w_we = 1'b0;
          end
        end
        ST_DRAIN: begin
          if (r_pend) begin
            w_we    = 1'b1;
            w_waddr = r_pend_addr;
            w_wdata = r_pend_data;
          end else begin
            w_we = 1'b0;
          end
        end
        ST_RUN: begin
          if (w_commit) begin
            w_we    = 1'b1;
            w_waddr = r_cap_addr;
            w_wdata = r_cap_data;
          end else begin
            w_we = 1'b0;
          end
        end
        default: w_we = 1'b0;
      endcase
    end
  end

  // Map storage
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // Control FSM, write capture and read pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_idx       <= 8'h00;
      r_init_done <= 1'b0;
      r_overrun   <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_addr <= 8'h00;
      r_pend_data <= 8'h00;
      r_cap_vld   <= 1'b0;
      r_cap_addr  <= 8'h00;
      r_cap_data  <= 8'h00;
      r_rd_addr   <= 8'h00;
      r_rd_data   <= 8'hFF;
    end else begin
      r_rd_addr <= MMU_ADDR;
      if (!r_init_done)
        r_rd_data <= default_map(r_rd_addr[2:0]);
      else if (w_we && (w_waddr == r_rd_addr))
        r_rd_data <= w_wdata;
      else
        r_rd_data <= r_mem[r_rd_addr];

      if (w_fall) begin
        r_cap_vld  <= 1'b1;
        r_cap_addr <= MMU_ADDR;
        r_cap_data <= MMU_DATA_in;
      end else if (w_rise) begin
        r_cap_vld  <= 1'b0;
      end

      case (r_state)
        ST_INIT: begin
          if (INIT_ON_RESET) begin
            if (w_commit) begin
              // newest write wins; losing a held one is flagged
              if (r_pend) r_overrun <= 1'b1;
              r_pend      <= 1'b1;
              r_pend_addr <= r_cap_addr;
              r_pend_data <= r_cap_data;
            end
            if (r_idx == 8'hFF) begin
              r_state <= ST_DRAIN;
            end else begin
              r_idx <= r_idx + 8'd1;
            end
          end else begin
            r_init_done <= 1'b1;
            r_state     <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          // the held entry is written this clk; a fresh commit takes its slot
          if (w_commit) begin
            r_pend      <= 1'b1;
            r_pend_addr <= r_cap_addr;
            r_pend_data <= r_cap_data;
          end else begin
            r_pend      <= 1'b0;
            r_init_done <= 1'b1;
            r_state     <= ST_RUN;
          end
        end
        ST_RUN: r_pend <= 1'b0;
        default: r_state <= ST_INIT;
      endcase
    end
  end

  // Bus resolution: mmu_int's own drive wins, then RAM read, else pulled high
  always_comb begin
    if (MMU_DATA_drv)
      MMU_DATA_out = MMU_DATA_in;
    else if (!MMU_nRD)
      MMU_DATA_out = r_rd_data;
    else
      MMU_DATA_out = 8'hFF;
  end

  assign init_done = r_init_done;
  assign overrun   = r_overrun;

endmodule
